// File: rtl/atp_rcpt_pkg.sv
// Shared types and constants for the ATP receipt generator.
// ATP_RCPT_CKSUM_EN selects the 12-byte receipt with a trailing XOR checksum.
package atp_rcpt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_EMIT
    } state_t;

    localparam logic [7:0] RCPT_HDR = 8'hA5;

`ifdef ATP_RCPT_CKSUM_EN
    localparam int RCPT_LEN = 12;
`else
    localparam int RCPT_LEN = 11;
`endif

    localparam int FLG_METHOD   = 0;
    localparam int FLG_DECLINED = 1;
    localparam int FLG_OVERPAY  = 2;

    localparam logic [3:0] IDX_HDR     = 4'd0;
    localparam logic [3:0] IDX_SEQ     = 4'd1;
    localparam logic [3:0] IDX_FLAGS   = 4'd2;
    localparam logic [3:0] IDX_CONS_HI = 4'd3;
    localparam logic [3:0] IDX_CONS_LO = 4'd4;
    localparam logic [3:0] IDX_AMT_HI  = 4'd5;
    localparam logic [3:0] IDX_AMT_LO  = 4'd6;
    localparam logic [3:0] IDX_CHG_HI  = 4'd7;
    localparam logic [3:0] IDX_CHG_LO  = 4'd8;
    localparam logic [3:0] IDX_BAL_HI  = 4'd9;
    localparam logic [3:0] IDX_BAL_LO  = 4'd10;
    localparam logic [3:0] IDX_CKSUM   = 4'd11;
    localparam logic [3:0] IDX_LAST    = 4'(RCPT_LEN - 1);

endpackage

// File: rtl/atp_receipt_gen_if.sv
// Transaction-in and receipt-byte-out handshakes of the ATP receipt generator.
interface atp_receipt_gen_if #(
    parameter int AMT_W  = 11,
    parameter int CONS_W = 12
);
    logic              txn_valid;
    logic              txn_ready;
    logic [CONS_W-1:0] txn_consumer;
    logic [AMT_W-1:0]  txn_amount;
    logic [AMT_W-1:0]  txn_charges;
    logic [AMT_W-1:0]  txn_old_bal;
    logic              txn_method;
    logic              txn_error;
    logic [7:0]        rcpt_data;
    logic              rcpt_valid;
    logic              rcpt_ready;
    logic              rcpt_last;

    modport master (
        output txn_valid, txn_consumer, txn_amount, txn_charges, txn_old_bal,
               txn_method, txn_error, rcpt_ready,
        input  txn_ready, rcpt_data, rcpt_valid, rcpt_last
    );

    modport slave (
        input  txn_valid, txn_consumer, txn_amount, txn_charges, txn_old_bal,
               txn_method, txn_error, rcpt_ready,
        output txn_ready, rcpt_data, rcpt_valid, rcpt_last
    );
endinterface

// File: rtl/atp_receipt_gen_balance.sv
// Post-payment balance: due = old_bal + charges, then settle against the amount tendered.
module atp_rcpt_balance #(
    parameter int AMT_W = 11
) (
    input  logic [AMT_W-1:0] amount,
    input  logic [AMT_W-1:0] charges,
    input  logic [AMT_W-1:0] old_bal,
    input  logic             error,
    output logic [AMT_W:0]   new_bal,
    output logic             declined,
    output logic             overpay
);
    logic [AMT_W:0] due;

    // A declined record leaves the whole amount due outstanding.
    always_comb begin
        due      = {1'b0, old_bal} + {1'b0, charges};
        new_bal  = due - {1'b0, amount};
        declined = 1'b0;
        overpay  = 1'b0;
        if (error) begin
            new_bal  = due;
            declined = 1'b1;
        end else if ({1'b0, amount} > due) begin
            new_bal = '0;
            overpay = 1'b1;
        end
    end
endmodule

// File: rtl/atp_receipt_gen.sv
// ATP receipt generator: captures one transaction record and streams a binary receipt.
// ATP_RCPT_CKSUM_EN appends an XOR checksum byte (12-byte receipt instead of 11).
module atp_receipt_gen
    import atp_rcpt_pkg::*;
#(
    parameter int AMT_W  = 11,
    parameter int CONS_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    atp_receipt_gen_if.slave   bus,
    output logic               busy,
    output logic [7:0]         seq_no
);
    state_t            state;
    logic [CONS_W-1:0] consumer_q;
    logic [AMT_W-1:0]  amount_q;
    logic [AMT_W-1:0]  charges_q;
    logic [AMT_W-1:0]  old_bal_q;
    logic              method_q;
    logic              error_q;
    logic [AMT_W:0]    new_bal_c;
    logic [AMT_W:0]    new_bal_q;
    logic              declined_c;
    logic              overpay_c;
    logic [7:0]        flags_c;
    logic [7:0]        flags_q;
    logic [3:0]        index;
    logic [3:0]        next_index;
    logic [7:0]        next_byte;
    logic [15:0]       cons16;
    logic [15:0]       amt16;
    logic [15:0]       chg16;
    logic [15:0]       bal16;
`ifdef ATP_RCPT_CKSUM_EN
    logic [7:0]        cksum_acc;
`endif

    atp_rcpt_balance #(.AMT_W(AMT_W)) u_balance (
        .amount   (amount_q),
        .charges  (charges_q),
        .old_bal  (old_bal_q),
        .error    (error_q),
        .new_bal  (new_bal_c),
        .declined (declined_c),
        .overpay  (overpay_c)
    );

    assign cons16     = 16'(consumer_q);
    assign amt16      = 16'(amount_q);
    assign chg16      = 16'(charges_q);
    assign bal16      = 16'(new_bal_q);
    assign next_index = index + 4'd1;

    always_comb begin
        flags_c               = '0;
        flags_c[FLG_METHOD]   = method_q;
        flags_c[FLG_DECLINED] = declined_c;
        flags_c[FLG_OVERPAY]  = overpay_c;
    end

    // Byte presented after the current one is accepted; the header is loaded from CALC.
    always_comb begin
        next_byte = 8'h00;
        case (next_index)
            IDX_SEQ:     next_byte = seq_no;
            IDX_FLAGS:   next_byte = flags_q;
            IDX_CONS_HI: next_byte = cons16[15:8];
            IDX_CONS_LO: next_byte = cons16[7:0];
            IDX_AMT_HI:  next_byte = amt16[15:8];
            IDX_AMT_LO:  next_byte = amt16[7:0];
            IDX_CHG_HI:  next_byte = chg16[15:8];
            IDX_CHG_LO:  next_byte = chg16[7:0];
            IDX_BAL_HI:  next_byte = bal16[15:8];
            IDX_BAL_LO:  next_byte = bal16[7:0];
`ifdef ATP_RCPT_CKSUM_EN
            IDX_CKSUM:   next_byte = cksum_acc ^ bus.rcpt_data;
`endif
            default:     next_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            seq_no         <= 8'h00;
            index          <= '0;
            consumer_q     <= '0;
            amount_q       <= '0;
            charges_q      <= '0;
            old_bal_q      <= '0;
            method_q       <= 1'b0;
            error_q        <= 1'b0;
            new_bal_q      <= '0;
            flags_q        <= '0;
            bus.txn_ready  <= 1'b1;
            bus.rcpt_data  <= 8'h00;
            bus.rcpt_valid <= 1'b0;
            bus.rcpt_last  <= 1'b0;
`ifdef ATP_RCPT_CKSUM_EN
            cksum_acc      <= 8'h00;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.txn_valid) begin
                        consumer_q    <= bus.txn_consumer;
                        amount_q      <= bus.txn_amount;
                        charges_q     <= bus.txn_charges;
                        old_bal_q     <= bus.txn_old_bal;
                        method_q      <= bus.txn_method;
                        error_q       <= bus.txn_error;
                        busy          <= 1'b1;
                        bus.txn_ready <= 1'b0;
                        state         <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    new_bal_q      <= new_bal_c;
                    flags_q        <= flags_c;
                    index          <= IDX_HDR;
                    bus.rcpt_data  <= RCPT_HDR;
                    bus.rcpt_valid <= 1'b1;
                    bus.rcpt_last  <= 1'b0;
`ifdef ATP_RCPT_CKSUM_EN
                    cksum_acc      <= 8'h00;
`endif
                    state          <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (bus.rcpt_ready) begin
`ifdef ATP_RCPT_CKSUM_EN
                        cksum_acc <= cksum_acc ^ bus.rcpt_data;
`endif
                        if (bus.rcpt_last) begin
                            bus.rcpt_valid <= 1'b0;
                            bus.rcpt_last  <= 1'b0;
                            bus.rcpt_data  <= 8'h00;
                            bus.txn_ready  <= 1'b1;
                            busy           <= 1'b0;
                            seq_no         <= seq_no + 8'd1;
                            state          <= ST_IDLE;
                        end else begin
                            index         <= next_index;
                            bus.rcpt_data <= next_byte;
                            bus.rcpt_last <= (next_index == IDX_LAST);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_atp_receipt_gen.sv
// Scoreboard bench for atp_receipt_gen: expected receipts are queued per record and
// popped as the printer side accepts bytes. Honours ATP_RCPT_CKSUM_EN like the design.
module tb_atp_receipt_gen;
    localparam int AMT_W  = 12;
    localparam int CONS_W = 12;
`ifdef ATP_RCPT_CKSUM_EN
    localparam int TB_LEN = 12;
`else
    localparam int TB_LEN = 11;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [7:0] seq_no;

    atp_receipt_gen_if #(.AMT_W(AMT_W), .CONS_W(CONS_W)) bus ();

    atp_receipt_gen #(.AMT_W(AMT_W), .CONS_W(CONS_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .busy   (busy),
        .seq_no (seq_no)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    logic [7:0] exp_bytes[12];
    logic [7:0] tb_seq = 8'h00;
    logic [8:0] mon_entry;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Independent receipt model; queues {last, byte} for each receipt byte.
    task automatic expect_receipt(input logic [CONS_W-1:0] cons, input logic [AMT_W-1:0] amt,
                                  input logic [AMT_W-1:0] chg, input logic [AMT_W-1:0] old,
                                  input logic method, input logic err);
        int          due;
        int          bal;
        logic [7:0]  flags;
        logic [7:0]  ck;
        logic [15:0] c16;
        logic [15:0] a16;
        logic [15:0] g16;
        logic [15:0] b16;
        due   = int'(old) + int'(chg);
        flags = {7'b0, method};
        if (err) begin
            bal      = due;
            flags[1] = 1'b1;
        end else if (int'(amt) > due) begin
            bal      = 0;
            flags[2] = 1'b1;
        end else begin
            bal = due - int'(amt);
        end
        c16 = 16'(cons);
        a16 = 16'(amt);
        g16 = 16'(chg);
        b16 = 16'(bal);
        exp_bytes[0]  = 8'hA5;
        exp_bytes[1]  = tb_seq;
        exp_bytes[2]  = flags;
        exp_bytes[3]  = c16[15:8];
        exp_bytes[4]  = c16[7:0];
        exp_bytes[5]  = a16[15:8];
        exp_bytes[6]  = a16[7:0];
        exp_bytes[7]  = g16[15:8];
        exp_bytes[8]  = g16[7:0];
        exp_bytes[9]  = b16[15:8];
        exp_bytes[10] = b16[7:0];
        ck = 8'h00;
        for (int i = 0; i < 11; i++) ck ^= exp_bytes[i];
        exp_bytes[11] = ck;
        for (int i = 0; i < TB_LEN; i++) exp_q.push_back({(i == TB_LEN - 1), exp_bytes[i]});
        tb_seq = tb_seq + 8'd1;
    endtask

    // Returns #1 after the capture edge.
    task automatic apply_stimulus(input int cons, input int amt, input int chg, input int old,
                                  input logic method, input logic err);
        int waited = 0;
        @(negedge clk);
        while (bus.txn_ready !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        check_output("txn_ready_before_send", bus.txn_ready, 1);
        expect_receipt(CONS_W'(cons), AMT_W'(amt), AMT_W'(chg), AMT_W'(old), method, err);
        bus.txn_consumer = CONS_W'(cons);
        bus.txn_amount   = AMT_W'(amt);
        bus.txn_charges  = AMT_W'(chg);
        bus.txn_old_bal  = AMT_W'(old);
        bus.txn_method   = method;
        bus.txn_error    = err;
        bus.txn_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.txn_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_output("queue_drained", exp_q.size(), 0);
        check_output("busy_after_receipt", busy, 0);
        check_output("seq_no_after_receipt", seq_no, tb_seq);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && bus.rcpt_valid === 1'b1 && bus.rcpt_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_byte", 32'(bus.rcpt_data) | 32'h100, 0);
            end else begin
                mon_entry = exp_q.pop_front();
                check_output("rcpt_data", bus.rcpt_data, mon_entry[7:0]);
                check_output("rcpt_last", bus.rcpt_last, mon_entry[8]);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst              = 1'b1;
        bus.txn_valid    = 1'b0;
        bus.txn_consumer = '0;
        bus.txn_amount   = '0;
        bus.txn_charges  = '0;
        bus.txn_old_bal  = '0;
        bus.txn_method   = 1'b0;
        bus.txn_error    = 1'b0;
        bus.rcpt_ready   = 1'b0;
        #12;
        check_output("reset_txn_ready", bus.txn_ready, 1);
        check_output("reset_rcpt_valid", bus.rcpt_valid, 0);
        check_output("reset_rcpt_last", bus.rcpt_last, 0);
        check_output("reset_rcpt_data", bus.rcpt_data, 8'h00);
        check_output("reset_busy", busy, 0);
        check_output("reset_seq_no", seq_no, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Plain cash payment with first-byte latency checks.
        bus.rcpt_ready = 1'b1;
        apply_stimulus(2816, 100, 50, 100, 1'b0, 1'b0);
        check_output("calc_busy", busy, 1);
        check_output("calc_txn_ready", bus.txn_ready, 0);
        check_output("calc_rcpt_valid", bus.rcpt_valid, 0);
        @(posedge clk);
        #1;
        check_output("first_byte_valid", bus.rcpt_valid, 1);
        check_output("first_byte_hdr", bus.rcpt_data, 8'hA5);
        wait_done();

        // Overpayment by cheque, then declined cash.
        apply_stimulus(2816, 2500, 50, 100, 1'b1, 1'b0);
        wait_done();
        apply_stimulus(2816, 2500, 50, 100, 1'b0, 1'b1);
        wait_done();

        // Backpressure on byte 4 with a stray record offered mid-receipt.
        apply_stimulus(12'h5C3, 40, 70, 30, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        bus.rcpt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.txn_consumer = 12'hFFF;
                bus.txn_amount   = 12'd7;
                bus.txn_valid    = 1'b1;
            end
            check_output("stall_rcpt_valid", bus.rcpt_valid, 1);
            check_output("stall_rcpt_data", bus.rcpt_data, exp_bytes[4]);
            check_output("stall_rcpt_last", bus.rcpt_last, 0);
            check_output("stall_txn_ready", bus.txn_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.txn_valid  = 1'b0;
        bus.rcpt_ready = 1'b1;
        wait_done();

        // Asynchronous reset while byte 6 is presented.
        apply_stimulus(12'h123, 300, 200, 50, 1'b1, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        check_output("byte6_before_reset", bus.rcpt_data, exp_bytes[6]);
        rst = 1'b1;
        #1;
        check_output("abort_rcpt_valid", bus.rcpt_valid, 0);
        check_output("abort_seq_no", seq_no, 8'h00);
        check_output("abort_busy", busy, 0);
        check_output("abort_txn_ready", bus.txn_ready, 1);
        check_output("abort_rcpt_data", bus.rcpt_data, 8'h00);
        check_output("abort_rcpt_last", bus.rcpt_last, 0);
        check_output("abort_pending_bytes", exp_q.size(), TB_LEN - 6);
        exp_q.delete();
        tb_seq = 8'h00;
        @(negedge clk);
        rst = 1'b0;

        // 257 back-to-back receipts: sequence runs 0x00..0xFF then wraps to 0x00.
        for (int r = 0; r < 257; r++) begin
            apply_stimulus(r * 13, r * 3, r, r * 2, r[0], (r % 7) == 3);
        end
        wait_done();
        check_output("seq_after_wrap", seq_no, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
